// File: rtl/toy_pe44_ctrl.sv
// ---------------------------------------------------------------------------
// toy_pe44_ctrl
//   Sequencer for a 4x4 skewed processing-element array. A job first streams
//   cfg_k operand beats into the array. It then idles for FLUSH_CYC cycles so
//   the skewed wavefront can drain. Next it strobes the accumulators into the
//   result chain, and finally shifts the four result rows out over a
//   valid/ready stream.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   start, cfg_k           job request and beat count (latched in IDLE)
//   busy, done             job in progress / one-cycle end-of-job pulse
//   op_valid/op_ready      operand stream handshake
//   op_x, op_y             row / column operand vectors
//   pe_din_en, pe_din,     registered operand drive into the array
//   pe_din_y
//   pe_load_en             accumulator capture strobe
//   pe_shift_en            result chain shift strobe
//   pe_shift_in            result chain fill value (always 0)
//   pe_shift_out           result chain head from the array
//   res_valid/res_ready    result stream handshake
//   res_data, res_last     result row and last-row marker
// ---------------------------------------------------------------------------
module toy_pe44_ctrl #(
  parameter int V_REG_WIDTH = 32,
  parameter int KW          = 8,
  parameter int FLUSH_CYC   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          cfg_k,
  output logic                   busy,
  output logic                   done,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [V_REG_WIDTH-1:0] op_x,
  input  logic [V_REG_WIDTH-1:0] op_y,
  output logic                   pe_din_en,
  output logic [V_REG_WIDTH-1:0] pe_din,
  output logic [V_REG_WIDTH-1:0] pe_din_y,
  output logic                   pe_load_en,
  output logic                   pe_shift_en,
  output logic [V_REG_WIDTH-1:0] pe_shift_in,
  input  logic [V_REG_WIDTH-1:0] pe_shift_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [V_REG_WIDTH-1:0] res_data,
  output logic                   res_last
);

  // Flush counter runs 0..FLUSH_CYC-1; FLUSH_CYC is expected to be >= 1.
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q;
  logic [KW-1:0]          beat_q;
  logic [FW-1:0]          flush_q;
  logic [1:0]             row_q;
  logic                   din_en_q;
  logic [V_REG_WIDTH-1:0] din_x_q;
  logic [V_REG_WIDTH-1:0] din_y_q;
  logic                   accept;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The last beat is recognised as beat_q == k_q-1 at
  // acceptance, so k_q = 2^KW-1 never needs a counter wider than KW bits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_k == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (accept && (beat_q == (k_q - KW'(1)))) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_DRAIN;
      S_DRAIN: begin
        if (pe_shift_en && (row_q == 2'd3)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. Everything here is a function of the current state and
  // the live handshake inputs.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    op_ready    = (state_q == S_FEED);
    pe_load_en  = (state_q == S_LOAD);
    res_valid   = (state_q == S_DRAIN);
    res_last    = (state_q == S_DRAIN) && (row_q == 2'd3);
    pe_shift_en = res_valid & res_ready;
    accept      = op_valid & op_ready;
  end

  // Job bookkeeping: latched beat count, beat/flush/row counters. The row
  // counter wraps 3->0 on the final handshake so it is ready for the next job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        k_q    <= cfg_k;
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + KW'(1);
      end
      if (state_q == S_FLUSH) begin
        flush_q <= flush_q + FW'(1);
      end else begin
        flush_q <= '0;
      end
      if (pe_shift_en) begin
        row_q <= row_q + 2'd1;
      end
    end
  end

  // Operand pipeline register. Data holds its last value across bubbles so the
  // array only sees fresh operands qualified by pe_din_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_en_q <= 1'b0;
      din_x_q  <= '0;
      din_y_q  <= '0;
    end else begin
      din_en_q <= accept;
      if (accept) begin
        din_x_q <= op_x;
        din_y_q <= op_y;
      end
    end
  end

  assign pe_din_en   = din_en_q;
  assign pe_din      = din_x_q;
  assign pe_din_y    = din_y_q;
  assign pe_shift_in = '0;
  assign res_data    = pe_shift_out;

endmodule

// File: tb/tb_toy_pe44_ctrl.sv
// ---------------------------------------------------------------------------
// tb_toy_pe44_ctrl
//   Self-checking bench for toy_pe44_ctrl. A job-level model tracks how many
//   beats, flush cycles and rows remain and predicts every output each cycle.
//   A small array stand-in answers pe_load_en/pe_shift_en with known rows.
//   Directed scenarios pin cycle-exact event times with literal values.
// ---------------------------------------------------------------------------
module tb_toy_pe44_ctrl;

  localparam int VW        = 32;
  localparam int KW        = 8;
  localparam int FLUSH_CYC = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] cfg_k;
  logic          busy, done;
  logic          op_valid, op_ready;
  logic [VW-1:0] op_x, op_y;
  logic          pe_din_en;
  logic [VW-1:0] pe_din, pe_din_y;
  logic          pe_load_en, pe_shift_en;
  logic [VW-1:0] pe_shift_in, pe_shift_out;
  logic          res_valid, res_ready, res_last;
  logic [VW-1:0] res_data;

  always #5 clk = ~clk;

  toy_pe44_ctrl #(.V_REG_WIDTH(VW), .KW(KW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k),
    .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
    .pe_din_en(pe_din_en), .pe_din(pe_din), .pe_din_y(pe_din_y),
    .pe_load_en(pe_load_en), .pe_shift_en(pe_shift_en),
    .pe_shift_in(pe_shift_in), .pe_shift_out(pe_shift_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last)
  );

  int testsRun  = 0;
  int failCount = 0;
  int cycNow    = 0;
  int startCyc  = 0;
  bit checkEn   = 1'b0;

  // Comparison helper shared by the per-cycle checker and the scenarios.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Known result row r of the job-th load.
  function automatic logic [VW-1:0] rowVal(input int job, input int r);
    return {8'(job), 8'(r + 1), 8'hA5, 8'(job * 3 + r)};
  endfunction

  always @(posedge clk) cycNow <= cycNow + 1;

  // Array stand-in: capture four rows on load, shift toward the head with
  // zero fill on each shift strobe.
  logic [VW-1:0] arr[4] = '{default: '0};
  int envJobs = 0;
  always @(posedge clk) begin
    if (pe_load_en) begin
      for (int i = 0; i < 4; i++) arr[i] <= rowVal(envJobs, i);
      envJobs <= envJobs + 1;
    end else if (pe_shift_en) begin
      arr[0] <= arr[1];
      arr[1] <= arr[2];
      arr[2] <= arr[3];
      arr[3] <= '0;
    end
  end
  assign pe_shift_out = arr[0];

  // Operand data changes every cycle so each accepted beat is identifiable.
  initial begin
    op_x = '0;
    op_y = '0;
    forever begin
      @(posedge clk);
      #1;
      op_x = {16'hA5A5 ^ 16'(cycNow), 16'(cycNow * 7)};
      op_y = {16'(cycNow * 13), 16'h3C3C ^ 16'(cycNow)};
    end
  end

  // Job-level model: remaining beats / flush cycles / rows.
  int            mFeedLeft = 0, mFlushLeft = 0, mRowsLeft = 0, mJobs = 0;
  bit            mLoad = 0, mDone = 0, mDinEn = 0;
  logic [VW-1:0] mDinX = '0, mDinY = '0;
  always @(posedge clk) begin
    bit acc, idle;
    acc  = (mFeedLeft > 0) && op_valid;
    idle = !((mFeedLeft > 0) || (mFlushLeft > 0) || mLoad || (mRowsLeft > 0) || mDone);
    if (!rst_n) begin
      mFeedLeft = 0; mFlushLeft = 0; mRowsLeft = 0;
      mLoad = 0; mDone = 0; mDinEn = 0; mDinX = '0; mDinY = '0;
    end else begin
      mDinEn = acc;
      if (acc) begin
        mDinX = op_x;
        mDinY = op_y;
      end
      if (idle) begin
        if (start) begin
          if (cfg_k == '0) mDone = 1;
          else mFeedLeft = int'(cfg_k);
        end
      end else if (mFeedLeft > 0) begin
        if (acc) begin
          mFeedLeft--;
          if (mFeedLeft == 0) mFlushLeft = FLUSH_CYC;
        end
      end else if (mFlushLeft > 0) begin
        mFlushLeft--;
        if (mFlushLeft == 0) mLoad = 1;
      end else if (mLoad) begin
        mLoad = 0;
        mRowsLeft = 4;
        mJobs++;
      end else if (mRowsLeft > 0) begin
        if (res_ready) begin
          mRowsLeft--;
          if (mRowsLeft == 0) mDone = 1;
        end
      end else if (mDone) begin
        mDone = 0;
      end
    end
  end

  // Event log, relative to the cycle start was presented; cleared at rel 0.
  int firstAcc, lastAcc, accCnt, firstDin, lastDin, dinCnt, loadCyc, loadCnt;
  int firstRv, rvCnt, shiftCnt, stallCnt, lastCnt, lastCyc, doneCnt, doneCyc, idleCyc;

  // Per-cycle compare against the model, plus event logging.
  always @(negedge clk) begin
    int rel;
    bit expValid;
    rel = cycNow - startCyc;
    if (checkEn) begin
      expValid = (mRowsLeft > 0);
      checkOutput("busy", busy,
                  (mFeedLeft > 0) || (mFlushLeft > 0) || mLoad || expValid || mDone);
      checkOutput("done", done, mDone);
      checkOutput("op_ready", op_ready, mFeedLeft > 0);
      checkOutput("pe_din_en", pe_din_en, mDinEn);
      checkOutput("pe_din", pe_din, mDinX);
      checkOutput("pe_din_y", pe_din_y, mDinY);
      checkOutput("pe_load_en", pe_load_en, mLoad);
      checkOutput("res_valid", res_valid, expValid);
      checkOutput("res_last", res_last, mRowsLeft == 1);
      checkOutput("pe_shift_en", pe_shift_en, expValid && res_ready);
      checkOutput("pe_shift_in", pe_shift_in, 0);
      if (expValid) checkOutput("res_data", res_data, rowVal(mJobs - 1, 4 - mRowsLeft));
    end
    if (rel == 0) begin
      firstAcc = -1; lastAcc = -1; accCnt = 0; firstDin = -1; lastDin = -1; dinCnt = 0;
      loadCyc = -1; loadCnt = 0; firstRv = -1; rvCnt = 0; shiftCnt = 0; stallCnt = 0;
      lastCnt = 0; lastCyc = -1; doneCnt = 0; doneCyc = -1; idleCyc = -1;
    end else begin
      if (op_valid && op_ready) begin
        if (accCnt == 0) firstAcc = rel;
        lastAcc = rel;
        accCnt++;
      end
      if (pe_din_en) begin
        if (dinCnt == 0) firstDin = rel;
        lastDin = rel;
        dinCnt++;
      end
      if (pe_load_en) begin
        loadCyc = rel;
        loadCnt++;
      end
      if (res_valid) begin
        if (rvCnt == 0) firstRv = rel;
        rvCnt++;
      end
      if (pe_shift_en) shiftCnt++;
      if (res_valid && !res_ready) stallCnt++;
      if (res_valid && res_last) begin
        lastCnt++;
        lastCyc = rel;
      end
      if (done) begin
        doneCnt++;
        doneCyc = rel;
      end
      if (!busy && idleCyc < 0) idleCyc = rel;
    end
  end

  // Present a start request for one cycle, then scramble cfg_k.
  task automatic applyStimulus(input logic [KW-1:0] k);
    @(posedge clk);
    #1;
    start    = 1'b1;
    cfg_k    = k;
    startCyc = cycNow;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_k = ~k;
  endtask

  // Bounded wait for the job to return to IDLE.
  task automatic runUntilIdle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      #1;
      if ((cycNow - startCyc) > 0 && !busy) ok = 1'b1;
    end
    checkOutput({name, "_reachedIdle"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] pat;
    bit         ok;
    rst_n = 1'b0; start = 1'b0; cfg_k = '0; op_valid = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_din", pe_din, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic job, k=4, no bubbles, no back-pressure.
    op_valid = 1'b1;
    res_ready = 1'b1;
    applyStimulus(8'd4);
    runUntilIdle("s1", 60);
    checkOutput("s1_firstAcc", firstAcc, 1);
    checkOutput("s1_lastAcc", lastAcc, 4);
    checkOutput("s1_firstDin", firstDin, 2);
    checkOutput("s1_lastDin", lastDin, 5);
    checkOutput("s1_dinCnt", dinCnt, 4);
    checkOutput("s1_loadCyc", loadCyc, 12);
    checkOutput("s1_firstRv", firstRv, 13);
    checkOutput("s1_lastCyc", lastCyc, 16);
    checkOutput("s1_doneCyc", doneCyc, 17);
    checkOutput("s1_idleCyc", idleCyc, 18);

    // k=3 with op_valid bubbles 1,0,0,1,1.
    op_valid = 1'b0;
    pat = 5'b11001;
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_k = 8'd3;
    startCyc = cycNow;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_k = 8'd9;
      op_valid = pat[i];
    end
    runUntilIdle("s2", 60);
    checkOutput("s2_accCnt", accCnt, 3);
    checkOutput("s2_dinCnt", dinCnt, 3);
    checkOutput("s2_lastAcc", lastAcc, 5);
    checkOutput("s2_loadGap", loadCyc - lastAcc, FLUSH_CYC + 1);
    checkOutput("s2_doneCyc", doneCyc, 18);

    // k=1 with the first result row stalled for 5 cycles.
    op_valid = 1'b1;
    res_ready = 1'b0;
    applyStimulus(8'd1);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (res_valid) ok = 1'b1;
    end
    checkOutput("s3_sawValid", ok, 1);
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b1;
    runUntilIdle("s3", 60);
    checkOutput("s3_firstRv", firstRv, 10);
    checkOutput("s3_stallCnt", stallCnt, 5);
    checkOutput("s3_shiftCnt", shiftCnt, 4);
    checkOutput("s3_lastCnt", lastCnt, 1);
    checkOutput("s3_lastCyc", lastCyc, 18);
    checkOutput("s3_doneCyc", doneCyc, 19);

    // k=0 goes straight to DONE without touching the array.
    applyStimulus(8'd0);
    runUntilIdle("s4", 10);
    checkOutput("s4_doneCyc", doneCyc, 1);
    checkOutput("s4_doneCnt", doneCnt, 1);
    checkOutput("s4_dinCnt", dinCnt, 0);
    checkOutput("s4_loadCnt", loadCnt, 0);
    checkOutput("s4_shiftCnt", shiftCnt, 0);
    checkOutput("s4_idleCyc", idleCyc, 2);

    // k=5 with a second start (k=2) during FEED that must be ignored.
    applyStimulus(8'd5);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_k = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    runUntilIdle("s5", 60);
    checkOutput("s5_accCnt", accCnt, 5);
    checkOutput("s5_dinCnt", dinCnt, 5);
    checkOutput("s5_loadCyc", loadCyc, 13);
    checkOutput("s5_doneCyc", doneCyc, 18);

    // Reset mid-FLUSH, then a fresh k=2 job.
    applyStimulus(8'd3);
    while ((cycNow - startCyc) < 6) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("s6_busy", busy, 0);
    checkOutput("s6_done", done, 0);
    checkOutput("s6_op_ready", op_ready, 0);
    checkOutput("s6_din_en", pe_din_en, 0);
    checkOutput("s6_load_en", pe_load_en, 0);
    checkOutput("s6_shift_en", pe_shift_en, 0);
    checkOutput("s6_res_valid", res_valid, 0);
    checkOutput("s6_res_last", res_last, 0);
    checkOutput("s6_din", pe_din, 0);
    checkOutput("s6_din_y", pe_din_y, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("s6_abortDone", doneCnt, 0);
    checkOutput("s6_abortRv", rvCnt, 0);
    applyStimulus(8'd2);
    runUntilIdle("s6", 60);
    checkOutput("s6_dinCnt", dinCnt, 2);
    checkOutput("s6_lastCyc", lastCyc, 14);
    checkOutput("s6_doneCyc", doneCyc, 15);

    // Largest legal beat count.
    applyStimulus(8'hFF);
    runUntilIdle("s7", 400);
    checkOutput("s7_dinCnt", dinCnt, 255);
    checkOutput("s7_lastCyc", lastCyc, 267);
    checkOutput("s7_doneCyc", doneCyc, 268);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/toy_pe44_ctrl.md
TOY_PE44_CTRL -- requirements
Module: toy_pe44_ctrl

Interface
REQ-001 SHALL have parameter V_REG_WIDTH, default 32: width of operand and result vectors (4 lanes x 8 bit).
REQ-002 SHALL have parameter KW, default 8: width of the beat-count configuration.
REQ-003 SHALL have parameter FLUSH_CYC, default 7: idle cycles after the last operand so the 4x4 skewed array settles.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-005 SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have the port start, input, 1 bit: job request, sampled only in IDLE.
REQ-007 SHALL have the port cfg_k, input, KW bits: operand beats per job, latched when start is accepted.
REQ-008 SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have the port done, output, 1 bit: one-cycle pulse at job end.
REQ-010 SHALL have the ports op_valid (input, 1 bit), op_ready (output, 1 bit), op_x (input, V_REG_WIDTH) and op_y (input, V_REG_WIDTH): operand stream, row vector and column vector.
REQ-011 SHALL have the ports pe_din_en (output, 1 bit), pe_din (output, V_REG_WIDTH) and pe_din_y (output, V_REG_WIDTH): array operand drive.
REQ-012 SHALL have the ports pe_load_en (output, 1 bit) and pe_shift_en (output, 1 bit): array accumulator capture and shift strobes.
REQ-013 SHALL have the ports pe_shift_in (output, V_REG_WIDTH, tied to 0) and pe_shift_out (input, V_REG_WIDTH): array result chain.
REQ-014 SHALL have the ports res_valid (output, 1 bit), res_ready (input, 1 bit), res_data (output, V_REG_WIDTH) and res_last (output, 1 bit): result stream, one row per beat.

Function
REQ-015 SHALL implement states IDLE, FEED, FLUSH, LOAD, DRAIN, DONE.
REQ-016 SHALL transition IDLE->FEED on start=1 with cfg_k!=0, and IDLE->DONE on start=1 with cfg_k==0, with no array strobes issued in the cfg_k==0 case.
REQ-017 SHALL drive op_ready=1 only in FEED; an accepted beat SHALL be op_valid&op_ready.
REQ-018 SHALL register each accepted beat: pe_din_en=1, pe_din=op_x and pe_din_y=op_y in the cycle after acceptance; otherwise pe_din_en=0 and pe_din/pe_din_y hold their last values.
REQ-019 SHALL tolerate op_valid bubbles in FEED, which produce pe_din_en=0 cycles without advancing the beat counter.
REQ-020 SHALL count accepted beats; the acceptance of beat cfg_k (counter==k-1) SHALL move FEED->FLUSH in the next cycle.
REQ-021 SHALL remain in FLUSH for exactly FLUSH_CYC cycles, then move to LOAD.
REQ-022 SHALL hold LOAD for exactly one cycle with pe_load_en=1, then move to DRAIN; pe_load_en SHALL be 0 in all other states.
REQ-023 SHALL, in DRAIN, drive res_valid=1 and res_data=pe_shift_out (combinational).
REQ-024 SHALL drive pe_shift_en=res_valid&res_ready.
REQ-025 SHALL count 4 row handshakes, 0..3, and assert res_last when the row counter equals 3.
REQ-026 SHALL move DRAIN->DONE on the handshake of row 3, and SHALL hold res_data stable while res_valid=1 and res_ready=0.
REQ-027 SHALL hold DONE for one cycle with done=1, then move to IDLE.
REQ-028 SHALL ignore start in every state except IDLE, and SHALL ignore changes to cfg_k after it is latched.
REQ-029 SHALL keep the beat counter KW bits wide with no wrap; cfg_k=2^KW-1 SHALL be legal.
REQ-030 SHALL tie pe_shift_in to 0 at all times.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear the beat, flush and row counters.
REQ-032 SHALL hold busy, done, op_ready, pe_din_en, pe_load_en, pe_shift_en, res_valid and res_last at 0 from the clock edge where rst_n=0 is sampled.
REQ-033 SHALL reset pe_din and pe_din_y to 0.
REQ-034 SHALL abandon a job in progress on reset mid-job without emitting done or res_valid.

Verification
REQ-035 SHALL be verified with: cfg_k=4, start at cycle 0, op_valid=1 always, res_ready=1 -> accepts at cycles 1-4, pe_din_en cycles 2-5, FLUSH cycles 5-11, pe_load_en at 12, res_valid at 13-16 with res_last at 16, done at 17, busy=0 at 18.
REQ-036 SHALL be verified with: cfg_k=3, op_valid pattern 1,0,0,1,1 -> exactly 3 pe_din_en pulses carrying op_x/op_y of the accepted beats, and LOAD occurring FLUSH_CYC+1 cycles after the last acceptance.
REQ-037 SHALL be verified with: DRAIN with res_ready=0 for 5 cycles, then 1 -> res_data stable and pe_shift_en=0 while stalled, 4 beats delivered in total, res_last only on the 4th.
REQ-038 SHALL be verified with: cfg_k=0 with start -> done at the next cycle, and no pe_din_en, pe_load_en or pe_shift_en.
REQ-039 SHALL be verified with: start pulsed during FEED with a different cfg_k -> ignored and beat count unchanged.
REQ-040 SHALL be verified with: rst_n=0 for 1 cycle during FLUSH -> IDLE next cycle, all REQ-032 outputs 0, then a fresh cfg_k=2 job completes normally.
